// File: rtl/core_pkg.sv
// Shared core definitions: memory arbiter state encoding
// and default bus geometry.
package core_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    // Largest latency the 3-bit counter can reach
    localparam int MEM_LAT_MAX = 7;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

endpackage

// File: rtl/flopenrc.sv
// Enabled register with synchronous clear.
// Clear wins over enable.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of the shared single-port SRAM.
// One access in flight; fixed latency; done pulses with bypass.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          stall_i,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          stall_d,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [2:0]    cnt;
    logic          last_d;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] i_hold;
    logic [DW-1:0] d_hold;

    logic idle;
    logic issue;
    logic grant_d;
    logic lat_hit;
    logic d_load_done;

    assign idle    = (state == IDLE);
    assign grant_d = d_req & (~i_req | ~last_d);
    assign issue   = ~rst & idle & (i_req | d_req);
    assign lat_hit = (cnt == 3'(MEM_LAT));

    assign i_done = ~rst & (state == BUSY_I) & lat_hit;
    assign d_done = ~rst & (state == BUSY_D) & lat_hit;

    assign d_load_done = d_done & ~we_q;

    assign stall_i = ~rst & i_req & ~i_done;
    assign stall_d = ~rst & d_req & ~d_done;

    // Addr/wdata hold the last issued values between issues
    assign mem_en    = issue;
    assign mem_we    = issue & grant_d & d_we;
    assign mem_addr  = rst   ? '0 :
                       issue ? (grant_d ? d_addr : i_addr) :
                               addr_q;
    assign mem_wdata = rst   ? '0 :
                       issue ? d_wdata :
                               wdata_q;

    assign i_rdata = i_done      ? mem_rdata : i_hold;
    assign d_rdata = d_load_done ? mem_rdata : d_hold;

    always_comb begin
        state_n = state;
        unique case (1'b1)
            issue & grant_d:  state_n = BUSY_D;
            issue & ~grant_d: state_n = BUSY_I;
            i_done | d_done:  state_n = IDLE;
            default:          state_n = state;
        endcase
        if (state == 2'd3) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            last_d  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            if (issue) begin
                cnt     <= 3'd1;
                last_d  <= grant_d;
                we_q    <= mem_we;
                addr_q  <= mem_addr;
                wdata_q <= d_wdata;
            end else if (i_done | d_done) begin
                cnt <= 3'd0;
            end else if (!idle) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    flopenrc #(
        .WIDTH (DW)
    ) u_i_hold (
        .clk (clk),
        .en  (i_done),
        .clr (rst),
        .d   (mem_rdata),
        .q   (i_hold)
    );

    flopenrc #(
        .WIDTH (DW)
    ) u_d_hold (
        .clk (clk),
        .en  (d_load_done),
        .clr (rst),
        .d   (mem_rdata),
        .q   (d_hold)
    );

endmodule
